// File: rtl/phys_reg_free_list_ctrl.sv
// Arbitration and commit-free buffering in front of the physical-register free list.
// Build option: define FREE_BUF_BYPASS_EN to let a free skip the empty buffer and reach the free list in the same cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// NORMAL   | dispatch may be granted
// RECOVER  | one cycle after a successful failed-speculation restore; fl_empty is stale
module phys_reg_free_list_ctrl #(
    parameter int FREE_BUF_DEPTH = 4,
    parameter int PHYS_REG_TAG_W = 6,
    parameter int ROB_INDEX_W    = 5,
    parameter int CKPT_COL_W     = 3
) (
    input  logic                      CLK,
    input  logic                      nRST,

    input  logic                      commit_free_valid,
    input  logic [PHYS_REG_TAG_W-1:0] commit_free_tag,
    output logic                      commit_free_ready,

    input  logic                      dispatch_req_valid,
    input  logic                      dispatch_req_save,
    input  logic [ROB_INDEX_W-1:0]    dispatch_req_ROB_index,
    output logic                      dispatch_grant,
    output logic [PHYS_REG_TAG_W-1:0] dispatch_phys_reg_tag,
    output logic [CKPT_COL_W-1:0]     dispatch_checkpoint_column,

    input  logic                      revert_req_valid,
    input  logic [PHYS_REG_TAG_W-1:0] revert_req_tag,
    output logic                      revert_ack,

    input  logic                      restore_req_valid,
    input  logic                      restore_req_speculate_failed,
    input  logic [ROB_INDEX_W-1:0]    restore_req_ROB_index,
    input  logic [CKPT_COL_W-1:0]     restore_req_column,
    output logic                      restore_done,
    output logic                      restore_success,

    output logic                      fl_dequeue_valid,
    input  logic [PHYS_REG_TAG_W-1:0] fl_dequeue_phys_reg_tag,
    input  logic                      fl_full,
    input  logic                      fl_empty,

    output logic                      fl_enqueue_valid,
    output logic [PHYS_REG_TAG_W-1:0] fl_enqueue_tag,

    output logic                      fl_revert_valid,
    output logic [PHYS_REG_TAG_W-1:0] fl_revert_tag,

    output logic                      fl_save_checkpoint_valid,
    output logic [ROB_INDEX_W-1:0]    fl_save_checkpoint_ROB_index,
    input  logic [CKPT_COL_W-1:0]     fl_save_checkpoint_safe_column,

    output logic                      fl_restore_checkpoint_valid,
    output logic                      fl_restore_checkpoint_speculate_failed,
    output logic [ROB_INDEX_W-1:0]    fl_restore_checkpoint_ROB_index,
    output logic [CKPT_COL_W-1:0]     fl_restore_checkpoint_column,
    input  logic                      fl_restore_checkpoint_success,

    output logic                      DUT_error
);

    // FREE_BUF_DEPTH must be a power of 2 and at least 2.
    localparam int PTR_W = $clog2(FREE_BUF_DEPTH);

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [PTR_W:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]            rd_ptr_q, rd_ptr_d;
    logic [PHYS_REG_TAG_W-1:0] buf_mem_q [FREE_BUF_DEPTH];
    logic [PHYS_REG_TAG_W-1:0] buf_mem_d [FREE_BUF_DEPTH];
    logic                      error_q, error_d;

    logic restore_failed;
    logic restore_recovers;
    logic dispatch_blocked;
    logic buf_empty;
    logic buf_full;
    logic free_accept;
    logic free_bypass;
    logic buf_push;
    logic buf_pop;

    // Request arbitration: restore > revert > dispatch
    always_comb begin
        restore_failed   = restore_req_valid && restore_req_speculate_failed;
        restore_recovers = restore_failed && fl_restore_checkpoint_success;
        dispatch_blocked = restore_failed || revert_req_valid || (state_q != ST_NORMAL);

        restore_done                           = restore_req_valid;
        restore_success                        = fl_restore_checkpoint_success;
        fl_restore_checkpoint_valid            = restore_req_valid;
        fl_restore_checkpoint_speculate_failed = restore_req_speculate_failed;
        fl_restore_checkpoint_ROB_index        = restore_req_ROB_index;
        fl_restore_checkpoint_column           = restore_req_column;

        revert_ack      = revert_req_valid && !restore_failed && (state_q == ST_NORMAL);
        fl_revert_valid = revert_ack;
        fl_revert_tag   = revert_req_tag;

        dispatch_grant = dispatch_req_valid && !dispatch_blocked
                         && (dispatch_req_save || !fl_empty);
        fl_dequeue_valid             = dispatch_grant && !dispatch_req_save;
        fl_save_checkpoint_valid     = dispatch_grant && dispatch_req_save;
        fl_save_checkpoint_ROB_index = dispatch_req_ROB_index;
        dispatch_phys_reg_tag        = fl_dequeue_phys_reg_tag;
        dispatch_checkpoint_column   = fl_save_checkpoint_safe_column;
    end

    // A second successful failed restore while recovering re-arms the stale-empty window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL:  if (restore_recovers) state_d = ST_RECOVER;
            ST_RECOVER: state_d = restore_recovers ? ST_RECOVER : ST_NORMAL;
            default:    state_d = ST_NORMAL;
        endcase
    end

    always_comb begin
        buf_empty = (wr_ptr_q == rd_ptr_q);
        buf_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W])
                    && (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        commit_free_ready = !buf_full;

        // Tag 0 is handshaken but never reaches the free list.
        free_accept = commit_free_valid && !buf_full && (commit_free_tag != '0);
`ifdef FREE_BUF_BYPASS_EN
        free_bypass = free_accept && buf_empty && !fl_full;
`else
        free_bypass = 1'b0;
`endif
        buf_push = free_accept && !free_bypass;
        buf_pop  = !buf_empty && !fl_full;

        fl_enqueue_valid = buf_pop || free_bypass;
        fl_enqueue_tag   = free_bypass ? commit_free_tag : buf_mem_q[rd_ptr_q[PTR_W-1:0]];

        buf_mem_d = buf_mem_q;
        if (buf_push) begin
            buf_mem_d[wr_ptr_q[PTR_W-1:0]] = commit_free_tag;
        end
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, buf_push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, buf_pop};
    end

    always_comb begin
        error_d = (commit_free_valid && buf_full)
                  || (revert_req_valid && (state_q == ST_RECOVER))
                  || (fl_enqueue_valid && fl_full);
        DUT_error = error_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_NORMAL;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            buf_mem_q <= '{default: '0};
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            buf_mem_q <= buf_mem_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: doc/phys_reg_free_list_ctrl.md
PHYS_REG_FREE_LIST_CTRL -- requirements
Module: phys_reg_free_list_ctrl

Interface
- REQ-001 SHALL: parameter FREE_BUF_DEPTH, default 4, depth of commit-free buffer (power of 2).
- REQ-002 SHALL: CLK  in  1  clock; reset nRST, asynchronous, active-low.
- REQ-003 SHALL: nRST  in  1  asynchronous active-low reset.
- REQ-004 SHALL: commit_free_valid / commit_free_tag  in  1 / phys_reg_tag_t  freed phys reg from commit.
- REQ-005 SHALL: commit_free_ready  out  1  buffer can accept this cycle.
- REQ-006 SHALL: dispatch_req_valid / dispatch_req_save  in  1 / 1  rename request; save=checkpoint (branch), else dequeue.
- REQ-007 SHALL: dispatch_req_ROB_index  in  ROB_index_t  ROB index for a save.
- REQ-008 SHALL: dispatch_grant  out  1  request performed this cycle.
- REQ-009 SHALL: dispatch_phys_reg_tag / dispatch_checkpoint_column  out  phys_reg_tag_t / checkpoint_column_t  pass-through of free-list head and save column.
- REQ-010 SHALL: revert_req_valid / revert_req_tag  in  1 / phys_reg_tag_t  ROB-walk revert of one speculative mapping.
- REQ-011 SHALL: revert_ack  out  1  revert performed this cycle.
- REQ-012 SHALL: restore_req_valid / restore_req_speculate_failed / restore_req_ROB_index / restore_req_column  in  1 / 1 / ROB_index_t / checkpoint_column_t  branch resolution.
- REQ-013 SHALL: restore_done / restore_success  out  1 / 1  resolution issued / free-list result.
- REQ-014 SHALL: fl_* ports  out/in  free-list widths  one-to-one drive of free-list dequeue, enqueue, revert, save, restore ports; fl_full, fl_empty, fl_dequeue_phys_reg_tag, fl_save_checkpoint_safe_column, fl_restore_checkpoint_success inputs.
- REQ-015 SHALL: DUT_error  out  1  registered protocol-error flag.

Function
- REQ-016 SHALL: at most one of fl_revert_valid, fl_restore_checkpoint_valid with speculate_failed, fl_save_checkpoint_valid, fl_dequeue_valid asserted per cycle.
- REQ-017 SHALL: priority restore > revert > dispatch; lower-priority request held off (no grant/ack) that cycle.
- REQ-018 SHALL: restore with speculate_failed=0 (checkpoint release) issued alongside revert or dispatch; restore_done same cycle as request.
- REQ-019 SHALL: FSM states NORMAL, RECOVER; NORMAL -> RECOVER on failed-speculation restore with fl_restore_checkpoint_success=1; RECOVER -> NORMAL after exactly 1 cycle; no dispatch grant in RECOVER (registered fl_empty stale).
- REQ-020 SHALL: dispatch dequeue granted only if ~fl_empty, state NORMAL, no restore/revert this cycle; save needs no empty check.
- REQ-021 SHALL: commit-free buffer FIFO FREE_BUF_DEPTH deep; ptrs with wrap msb; commit_free_ready = ~buf_full.
- REQ-022 SHALL: tag 0 accepted (ready honoured) but dropped, never enqueued.
- REQ-023 SHALL: buffer head drained to fl_enqueue one per cycle when non-empty and ~fl_full, independent of other operations; simultaneous push and pop on full buffer not accepted (ready=0).
- REQ-024 SHALL: DUT_error next cycle on commit_free_valid with ready=0, revert_req_valid in RECOVER, or fl_enqueue while fl_full.

Reset
- REQ-025 SHALL: reset state NORMAL, buffer empty, commit_free_ready=1, DUT_error=0, all fl_*_valid/grant/ack/done outputs 0.
- REQ-026 SHALL: reset mid-operation discards buffered frees and any pending RECOVER.

Configuration
- REQ-027 SHALL: macro FREE_BUF_BYPASS_EN defined: commit free with empty buffer and ~fl_full drives fl_enqueue same cycle (0-cycle latency); undefined: every free passes through buffer (1-cycle latency).

Verification
- REQ-028 SHALL: dispatch dequeue, head=tag 40, no conflicts -> dispatch_grant=1, fl_dequeue_valid=1, dispatch_phys_reg_tag=40.
- REQ-029 SHALL: restore failed + dispatch same cycle, success=1 -> fl_restore issued, dispatch_grant=0 that cycle and next (RECOVER), granted cycle 3.
- REQ-030 SHALL: revert tag 17 + dispatch save same cycle -> revert_ack=1, fl_revert tag 17, grant 0; save granted next cycle.
- REQ-031 SHALL: 5 back-to-back frees, depth 4, fl_full=1 -> ready=0 after 4th; fl_full deassert -> 4 enqueues in order.
- REQ-032 SHALL: commit free tag 0 -> ready=1, fl_enqueue never asserted, buffer count unchanged.
- REQ-033 SHALL: free tag 9, empty buffer -> fl_enqueue cycle 0 with FREE_BUF_BYPASS_EN, cycle 1 without.
